// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t      : FSM state encodings (IDLE / SHIFT / GAP / DONE)
//   PAT_DEFAULT  : reference pattern word used by detectors and benches
//   *_WIDTH_DEF  : default parameter widths for pattern_generator
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int PAT_WIDTH_DEF = 5;
    localparam int LEN_WIDTH_DEF = 3;
    localparam int REP_WIDTH_DEF = 8;
    localparam int GAP_WIDTH_DEF = 4;

    localparam logic [PAT_WIDTH_DEF-1:0] PAT_DEFAULT = 5'b11010;

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable MSB-first shift register with a bits-remaining down-counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear of register and counter
//   load     : load data/len (len must be 1..W); has priority over shift
//   shift    : advance to the next bit
//   data     : pattern word, bit [len-1] is emitted first
//   len      : frame length in bits
//   msb      : bit currently on the line (registered)
//   last     : the bit on the line is the last of the frame (registered)
// The word is left-aligned at load, so after len shifts the register is all
// zeros and msb reads 0 with no extra gating.
module pattern_shift_reg #(
    parameter int W  = 5,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    output logic          msb,
    output logic          last
);

    localparam logic [LW-1:0] W_L = LW'(W);

    logic [W-1:0]  sr_reg,   sr_next;
    logic [LW-1:0] cnt_reg,  cnt_next;
    logic          last_reg, last_next;
    logic [LW-1:0] align_shamt;

    assign align_shamt = W_L - len;

    always_comb begin
        sr_next  = sr_reg;
        cnt_next = cnt_reg;
        if (clr) begin
            sr_next  = '0;
            cnt_next = '0;
        end else if (load) begin
            sr_next  = data << align_shamt;
            cnt_next = len;
        end else if (shift && cnt_reg != '0) begin
            sr_next  = {sr_reg[W-2:0], 1'b0};
            cnt_next = cnt_reg - 1'b1;
        end
        last_next = (cnt_next == LW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg   <= '0;
            cnt_reg  <= '0;
            last_reg <= 1'b0;
        end else begin
            sr_reg   <= sr_next;
            cnt_reg  <= cnt_next;
            last_reg <= last_next;
        end
    end

    assign msb  = sr_reg[W-1];
    assign last = last_reg;

endmodule

// File: rtl/pattern_generator.sv
// Serial bit-pattern transmitter. On start (in IDLE) captures a pattern word and
// sends it MSB-first, one bit per clk, for repeat_cnt+1 frames separated by
// gap_len idle cycles, then pulses done for one cycle.
//   clk, rst       : clock, synchronous active-high reset
//   start, abort   : transfer request / synchronous cancel (abort wins)
//   pat_word       : pattern bits, bit [pat_len-1] sent first
//   pat_len        : bits per frame (0 or >PAT_WIDTH clamps to PAT_WIDTH)
//   repeat_cnt     : extra frames
//   gap_len        : idle cycles between frames
//   pattern        : serial data bit
//   pattern_valid  : pattern carries a frame bit
//   frame_last     : current bit is last of its frame
//   busy           : not IDLE
//   done           : one-cycle completion pulse
// All outputs are registers updated on the same edge as the state register, so
// the observed state and the outputs always agree.
module pattern_generator
    import pattern_pkg::*;
#(
    parameter int PAT_WIDTH = PAT_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int REP_WIDTH = REP_WIDTH_DEF,
    parameter int GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_WIDTH-1:0] pat_word,
    input  logic [LEN_WIDTH-1:0] pat_len,
    input  logic [REP_WIDTH-1:0] repeat_cnt,
    input  logic [GAP_WIDTH-1:0] gap_len,
    output logic                 pattern,
    output logic                 pattern_valid,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(PAT_WIDTH);

    state_t               state_reg,   state_next;
    logic [PAT_WIDTH-1:0] word_reg,    word_next;
    logic [LEN_WIDTH-1:0] len_reg,     len_next;
    logic [REP_WIDTH-1:0] frames_reg,  frames_next;
    logic [GAP_WIDTH-1:0] gap_len_reg, gap_len_next;
    logic [GAP_WIDTH-1:0] gap_cnt_reg, gap_cnt_next;
    logic                 valid_reg, busy_reg, done_reg;

    logic                 sr_clr, sr_load, sr_shift, sr_last;
    logic [PAT_WIDTH-1:0] sr_data;
    logic [LEN_WIDTH-1:0] sr_len;
    logic [LEN_WIDTH-1:0] len_clamped;

    assign len_clamped = (pat_len == '0 || pat_len > MAX_LEN) ? MAX_LEN : pat_len;

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        len_next     = len_reg;
        frames_next  = frames_reg;
        gap_len_next = gap_len_reg;
        gap_cnt_next = gap_cnt_reg;
        sr_clr       = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_data      = word_reg;
        sr_len       = len_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    word_next    = pat_word;
                    len_next     = len_clamped;
                    frames_next  = repeat_cnt;
                    gap_len_next = gap_len;
                    sr_load      = 1'b1;
                    sr_data      = pat_word;
                    sr_len       = len_clamped;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    sr_clr     = 1'b1;
                    state_next = ST_IDLE;
                end else if (sr_last) begin
                    if (frames_reg != '0) begin
                        frames_next = frames_reg - 1'b1;
                        if (gap_len_reg != '0) begin
                            sr_shift     = 1'b1;
                            gap_cnt_next = gap_len_reg;
                            state_next   = ST_GAP;
                        end else begin
                            // Reload on the last bit so the next frame follows with no bubble.
                            sr_load = 1'b1;
                        end
                    end else begin
                        sr_shift   = 1'b1;
                        state_next = ST_DONE;
                    end
                end else begin
                    sr_shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    sr_clr     = 1'b1;
                    state_next = ST_IDLE;
                end else if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                    sr_load    = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                sr_clr     = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            word_reg    <= '0;
            len_reg     <= '0;
            frames_reg  <= '0;
            gap_len_reg <= '0;
            gap_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            len_reg     <= len_next;
            frames_reg  <= frames_next;
            gap_len_reg <= gap_len_next;
            gap_cnt_reg <= gap_cnt_next;
            valid_reg   <= (state_next == ST_SHIFT);
            busy_reg    <= (state_next != ST_IDLE);
            done_reg    <= (state_next == ST_DONE);
        end
    end

    pattern_shift_reg #(
        .W  (PAT_WIDTH),
        .LW (LEN_WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .clr   (sr_clr),
        .load  (sr_load),
        .shift (sr_shift),
        .data  (sr_data),
        .len   (sr_len),
        .msb   (pattern),
        .last  (sr_last)
    );

    assign pattern_valid = valid_reg;
    assign frame_last    = sr_last;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule
